store_buffer: RTL and testbench

- Write-posting FIFO between the MEM-stage store/load request and the data memory's single shared port (A/WD/DM_op/WE).
- Stores retire to the buffer in one cycle and drain to memory one per cycle whenever the port is free.
- Loads take the port with priority. A load that overlaps any pending store stalls until the store has drained.

---
 rtl/store_buffer.sv | 143 ++++++++++++++
 tb/tb_store_buffer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: write-posting FIFO that holds retired stores and drains them to the shared data-memory port.
// Optional macro STORE_FWD_EN: a word load whose youngest matching store is a word store is served from the buffer.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [31:0]   st_addr,
  input  logic [31:0]   st_data,
  input  logic [2:0]    st_op,
  input  logic [31:0]   st_pc,
  input  logic [31:0]   st_instr,
  input  logic          ld_valid,
  input  logic [31:0]   ld_addr,
  input  logic [2:0]    ld_op,
  output logic          ld_stall,
  output logic          ld_fwd_valid,
  output logic [31:0]   ld_fwd_data,
  input  logic          drain_req,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          dm_we,
  output logic [31:0]   dm_a,
  output logic [31:0]   dm_wd,
  output logic [2:0]    dm_op,
  output logic [31:0]   dm_pc,
  output logic [31:0]   dm_instr
);
  localparam int PW = $clog2(DEPTH);
`ifdef STORE_FWD_EN
  localparam logic [2:0] DM_W = 3'd0;
`endif

  logic [31:0] addr_mem  [DEPTH];
  logic [31:0] data_mem  [DEPTH];
  logic [2:0]  op_mem    [DEPTH];
  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr, idx;
  logic [CW-1:0] count_q, count_next;
  logic          drain_pend;
  logic          push, pop, hit, ld_port;
`ifdef STORE_FWD_EN
  logic          fwd_ok;
  logic [31:0]   fwd_data;
`endif

  assign empty    = (count_q == '0);
  assign count    = count_q;
  // Once a flush is requested, pushes stay blocked until everything already posted has reached memory.
  assign st_ready = (count_q < CW'(DEPTH)) && !drain_pend && !(drain_req && !empty);
  assign push     = st_valid && st_ready;

  // Scan oldest to youngest so the last match seen is the youngest store to that word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hit = 1'b0;
    idx = rd_ptr;
`ifdef STORE_FWD_EN
    fwd_ok   = 1'b0;
    fwd_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if ((CW'(k) < count_q) && (addr_mem[idx][31:2] == ld_addr[31:2])) begin
        hit = 1'b1;
`ifdef STORE_FWD_EN
        fwd_ok   = (op_mem[idx] == DM_W) && (ld_op == DM_W);
        fwd_data = data_mem[idx];
`endif
      end
    end
    if (push && (st_addr[31:2] == ld_addr[31:2])) begin
      hit = 1'b1;
`ifdef STORE_FWD_EN
      fwd_ok   = (st_op == DM_W) && (ld_op == DM_W);
      fwd_data = st_data;
`endif
    end
    if (!ld_valid || reset) hit = 1'b0;
  end

`ifdef STORE_FWD_EN
  assign ld_fwd_valid = hit && fwd_ok;
  assign ld_fwd_data  = ld_fwd_valid ? fwd_data : '0;
`else
  assign ld_fwd_valid = 1'b0;
  assign ld_fwd_data  = '0;
`endif
  assign ld_stall = hit && !ld_fwd_valid;

  // A clean load owns the port; otherwise the head entry drains.
  assign ld_port = ld_valid && !hit;
  assign pop     = !ld_port && !empty;

  always_comb begin
    dm_we    = pop;
    dm_a     = ld_addr;
    dm_op    = ld_op;
    dm_wd    = '0;
    dm_pc    = '0;
    dm_instr = '0;
    if (pop) begin
      dm_a     = addr_mem[rd_ptr];
      dm_wd    = data_mem[rd_ptr];
      dm_op    = op_mem[rd_ptr];
      dm_pc    = pc_mem[rd_ptr];
      dm_instr = instr_mem[rd_ptr];
    end
  end

  assign count_next = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      drain_pend <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every update sees pre-edge values.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count_q    <= count_next;
      drain_pend <= (drain_pend || drain_req) && (count_next != '0);
    end
  end

  // NOTE: entry storage is not reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr]  <= st_addr;
      data_mem[wr_ptr]  <= st_data;
      op_mem[wr_ptr]    <= st_op;
      pc_mem[wr_ptr]    <= st_pc;
      instr_mem[wr_ptr] <= st_instr;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: scoreboard of posted stores against memory-port writes, plus a memory model.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam logic [2:0] DM_W = 3'd0, DM_H = 3'd1, DM_B = 3'd3, DM_BU = 3'd4;
`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic st_valid, st_ready;
  logic [31:0] st_addr, st_data, st_pc, st_instr;
  logic [2:0] st_op;
  logic ld_valid, ld_stall, ld_fwd_valid;
  logic [31:0] ld_addr, ld_fwd_data;
  logic [2:0] ld_op;
  logic drain_req, empty;
  logic [CW-1:0] count;
  logic dm_we;
  logic [31:0] dm_a, dm_wd, dm_pc, dm_instr;
  logic [2:0] dm_op;

  store_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_op(st_op), .st_pc(st_pc), .st_instr(st_instr),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_op(ld_op), .ld_stall(ld_stall),
    .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
    .drain_req(drain_req), .empty(empty), .count(count),
    .dm_we(dm_we), .dm_a(dm_a), .dm_wd(dm_wd), .dm_op(dm_op), .dm_pc(dm_pc), .dm_instr(dm_instr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  op;
    logic [31:0] pc;
    logic [31:0] instr;
  } st_t;

  st_t         sb_q[$];
  st_t         e;
  logic [31:0] dmem    [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];
  int errors = 0, checks = 0, writes = 0, pushes = 0, seq = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                        input logic [31:0] d, input logic [2:0] op);
    logic [31:0] r;
    r = old;
    case (op)
      DM_B:    r[a[1:0]*8 +: 8]  = d[7:0];
      DM_H:    r[a[1]*16 +: 16]  = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rd_dmem(input logic [31:0] a);
    return dmem.exists(a[31:2]) ? dmem[a[31:2]] : 32'h0;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : 32'h0;
  endfunction

  // Expected stall from the scoreboard: pending stores are exactly the queue contents.
  function automatic logic exp_stall();
    logic h, fw;
    h = 1'b0;
    fw = 1'b0;
    if (!ld_valid) return 1'b0;
    foreach (sb_q[i])
      if (sb_q[i].addr[31:2] == ld_addr[31:2]) begin
        h  = 1'b1;
        fw = (sb_q[i].op == DM_W) && (ld_op == DM_W);
      end
    if (st_valid && st_ready && (st_addr[31:2] == ld_addr[31:2])) begin
      h  = 1'b1;
      fw = (st_op == DM_W) && (ld_op == DM_W);
    end
    return h && !(fw && FWD);
  endfunction

  // Monitor on the falling edge: inputs and combinational outputs are stable for the coming posedge.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
    end else begin
      if (dm_we) begin
        check("write_pending", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("wr_addr", dm_a, e.addr);
          check("wr_data", dm_wd, e.data);
          check("wr_op", 32'(dm_op), 32'(e.op));
          check("wr_pc", dm_pc, e.pc);
          check("wr_instr", dm_instr, e.instr);
        end
        dmem[dm_a[31:2]] = merge(rd_dmem(dm_a), dm_a, dm_wd, dm_op);
        writes++;
      end
      if (st_valid && st_ready) begin
        sb_q.push_back('{st_addr, st_data, st_op, st_pc, st_instr});
        ref_mem[st_addr[31:2]] = merge(rd_ref(st_addr), st_addr, st_data, st_op);
        pushes++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_op = DM_W; st_pc = '0; st_instr = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_op = DM_W; drain_req = 1'b0;
  endtask

  task automatic drive_st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
    seq++;
    st_valid = 1'b1; st_addr = a; st_data = d; st_op = op;
    st_pc    = 32'h0040_0000 + 32'(seq * 4);
    st_instr = $urandom;
  endtask

  task automatic drive_ld(input logic [31:0] a, input logic [2:0] op);
    ld_valid = 1'b1; ld_addr = a; ld_op = op;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (!empty && n < 64) begin
      tick();
      n++;
    end
    check(tag, 32'(empty), 32'd1);
  endtask

  task automatic wait_unstall(input string tag);
    int n;
    n = 0;
    while (ld_stall && n < 16) begin
      tick();
      n++;
    end
    check(tag, 32'(ld_stall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pushed;
    bit acc;
    logic [31:0] ca, cd;
    logic [2:0]  cop;

    idle();
    reset = 1'b1;
    tick(); tick();
    // Outputs under reset, with colliding store/load requests present.
    drive_st(32'h8, 32'h1, DM_W);
    drive_ld(32'h8, DM_W);
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ready", 32'(st_ready), 32'd1);
    check("rst_stall", 32'(ld_stall), 32'd0);
    check("rst_we", 32'(dm_we), 32'd0);
    check("rst_fwd", 32'(ld_fwd_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    idle();
    tick();
    reset = 1'b0;

    // Reset mid-drain: three posted stores, one drain, then async reset.
    writes = 0;
    drive_ld(32'h100, DM_W);
    drive_st(32'h20, 32'hA1, DM_W); tick();
    drive_st(32'h24, 32'hA2, DM_W); tick();
    drive_st(32'h28, 32'hA3, DM_W); tick();
    st_valid = 1'b0;
    #1;
    check("rmd_count3", 32'(count), 32'd3);
    check("rmd_ld_port", dm_a, 32'h100);
    ld_valid = 1'b0;
    #1;
    check("rmd_drain_we", 32'(dm_we), 32'd1);
    check("rmd_drain_a", dm_a, 32'h20);
    tick();
    check("rmd_count2", 32'(count), 32'd2);
    reset = 1'b1;
    #1;
    check("rmd_count0", 32'(count), 32'd0);
    check("rmd_empty", 32'(empty), 32'd1);
    check("rmd_we", 32'(dm_we), 32'd0);
    tick();
    reset = 1'b0;
    tick(); tick();
    check("rmd_writes", 32'(writes), 32'd1);
    check("rmd_still_empty", 32'(empty), 32'd1);

    // Fill without loads: drains keep pace, never full.
    for (int i = 0; i < 5; i++) begin
      drive_st(32'(i * 4), 32'hA000_0000 + 32'(i), DM_W);
      #1;
      check("fill_ready", 32'(st_ready), 32'd1);
      tick();
    end
    idle();
    wait_empty("fill_drain");

    // Backpressure: a held load blocks drains so the buffer fills.
    drive_ld(32'h100, DM_W);
    for (int i = 0; i < 4; i++) begin
      drive_st(32'h60 + 32'(i * 4), 32'hB000_0000 + 32'(i), DM_W);
      #1;
      check("bp_ready", 32'(st_ready), 32'd1);
      tick();
    end
    drive_st(32'h70, 32'hB000_0004, DM_W);
    #1;
    check("bp_count4", 32'(count), 32'd4);
    check("bp_full", 32'(st_ready), 32'd0);
    tick();
    check("bp_hold_count", 32'(count), 32'd4);
    ld_valid = 1'b0;
    #1;
    check("bp_no_same_cycle", 32'(st_ready), 32'd0);
    check("bp_drain_a", dm_a, 32'h60);
    tick();
    check("bp_ready_again", 32'(st_ready), 32'd1);
    tick();
    st_valid = 1'b0;
    check("bp_count3", 32'(count), 32'd3);
    wait_empty("bp_drain");

    // Load hazard on a pending word store.
    dmem.delete();
    drive_st(32'h8, 32'h1234_5678, DM_W); tick();
    st_valid = 1'b0;
    drive_ld(32'hA, DM_W);
    #1;
    check("hz_stall", 32'(ld_stall), 32'(!FWD));
    check("hz_fwd_v", 32'(ld_fwd_valid), 32'(FWD));
    check("hz_fwd_d", ld_fwd_data, FWD ? 32'h1234_5678 : 32'h0);
    check("hz_drain_we", 32'(dm_we), 32'd1);
    check("hz_drain_a", dm_a, 32'h8);
    tick();
    check("hz_clear", 32'(ld_stall), 32'd0);
    check("hz_ld_port", dm_a, 32'hA);
    check("hz_ld_we", 32'(dm_we), 32'd0);
    check("hz_data", rd_dmem(dm_a), 32'h1234_5678);
    idle();

    // Hazard against the incoming store in the same cycle (half store: never forwarded).
    drive_st(32'h30, 32'h0000_BEEF, DM_H);
    drive_ld(32'h30, DM_W);
    #1;
    check("inc_h_stall", 32'(ld_stall), 32'd1);
    check("inc_h_we", 32'(dm_we), 32'd0);
    check("inc_h_fwd", 32'(ld_fwd_valid), 32'd0);
    tick();
    idle();
    tick();
    drive_st(32'h34, 32'hCAFE_F00D, DM_W);
    drive_ld(32'h34, DM_W);
    #1;
    check("inc_w_stall", 32'(ld_stall), 32'(!FWD));
    check("inc_w_fwd_d", ld_fwd_data, FWD ? 32'hCAFE_F00D : 32'h0);
    tick();
    idle();
    wait_empty("inc_drain");

    // Partial overlap: byte store then word load of the same word.
    drive_st(32'h5, 32'h0000_00AB, DM_B); tick();
    st_valid = 1'b0;
    drive_ld(32'h4, DM_W);
    #1;
    check("po_stall", 32'(ld_stall), 32'd1);
    check("po_fwd", 32'(ld_fwd_valid), 32'd0);
    wait_unstall("po_unstall");
    check("po_data", rd_dmem(32'h4), 32'h0000_AB00);
    idle();

    // Older word followed by a younger byte to the same word: always stalls.
    drive_ld(32'h100, DM_W);
    drive_st(32'h40, 32'h1122_3344, DM_W); tick();
    drive_st(32'h41, 32'h0000_0055, DM_B); tick();
    st_valid = 1'b0;
    ld_addr = 32'h40;
    #1;
    check("ow_stall", 32'(ld_stall), 32'd1);
    check("ow_fwd", 32'(ld_fwd_valid), 32'd0);
    wait_unstall("ow_unstall");
    check("ow_data", rd_dmem(32'h40), 32'h1122_5544);
    idle();
    wait_empty("ow_drain");

    // Priority: a clean load keeps the port; pending stores drain afterwards in order.
    drive_ld(32'h40, DM_W);
    drive_st(32'h50, 32'hC0, DM_W); tick();
    drive_st(32'h54, 32'hC1, DM_W); tick();
    st_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("pri_we", 32'(dm_we), 32'd0);
      check("pri_a", dm_a, 32'h40);
      check("pri_stall", 32'(ld_stall), 32'd0);
      tick();
    end
    ld_valid = 1'b0;
    #1;
    check("pri_d1_we", 32'(dm_we), 32'd1);
    check("pri_d1_a", dm_a, 32'h50);
    tick();
    check("pri_d2_we", 32'(dm_we), 32'd1);
    check("pri_d2_a", dm_a, 32'h54);
    tick();
    check("pri_empty", 32'(empty), 32'd1);
    check("pri_idle_we", 32'(dm_we), 32'd0);

    // Pointer wrap with interleaved loads, then a flush.
    dmem.delete();
    ref_mem.delete();
    writes = 0;
    pushes = 0;
    pushed = 0;
    n = 0;
    ca = 32'h200 + 32'($urandom_range(7) * 4) + 32'($urandom_range(3));
    cd = $urandom;
    cop = ($urandom_range(2) == 0) ? DM_W : (($urandom_range(1) == 0) ? DM_H : DM_B);
    if (cop == DM_W) ca[1:0] = 2'b00;
    if (cop == DM_H) ca[0] = 1'b0;
    while (pushed < 10 && n < 200) begin
      drive_st(ca, cd, cop);
      if (n % 2 == 0) drive_ld(32'h100, DM_W);
      else drive_ld(32'h200 + 32'($urandom_range(7) * 4), ($urandom_range(1) == 0) ? DM_W : DM_BU);
      #1;
      check("w_count", 32'(count), 32'(sb_q.size()));
      check("w_ready", 32'(st_ready), 32'(sb_q.size() < DEPTH));
      check("w_stall", 32'(ld_stall), 32'(exp_stall()));
      acc = st_ready;
      tick();
      if (acc) begin
        pushed++;
        ca = 32'h200 + 32'($urandom_range(7) * 4) + 32'($urandom_range(3));
        cd = $urandom;
        cop = ($urandom_range(2) == 0) ? DM_W : (($urandom_range(1) == 0) ? DM_H : DM_B);
        if (cop == DM_W) ca[1:0] = 2'b00;
        if (cop == DM_H) ca[0] = 1'b0;
      end
      n++;
    end
    check("w_pushed", 32'(pushed), 32'd10);

    idle();
    drive_st(32'h220, 32'hDEAD_BEEF, DM_W);
    drain_req = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 32) begin
      #1;
      check("dr_ready", 32'(st_ready), 32'(sb_q.size() == 0));
      acc = st_ready;
      tick();
      drain_req = 1'b0;
      n++;
    end
    st_valid = 1'b0;
    check("dr_accepted", 32'(acc), 32'd1);
    wait_empty("dr_drain");
    tick();
    check("dr_sb_empty", 32'(sb_q.size()), 32'd0);
    check("dr_writes", 32'(writes), 32'(pushes));
    foreach (ref_mem[w]) check("dr_mem", rd_dmem({w, 2'b00}), ref_mem[w]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
